// File: rtl/cpu_fetch_pc.sv
// Fetch PC generator with a direct-mapped BTB and a one-deep output register.
// The predictor direction is qualified by a BTB hit before a target is followed.
module cpu_fetch_pc #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pred_addr,
    input  logic        pred_taken,
    input  logic        btb_update,
    input  logic [31:0] btb_update_pc,
    input  logic [31:0] btb_update_target,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic        out_pred_taken,
    output logic [31:0] out_pred_target
);

    localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = 30 - IDX;

    logic [31:0]            pc_q, pc_d;
    logic                   out_valid_q, out_valid_d;
    logic [31:0]            out_pc_q, out_pc_d;
    logic                   out_pred_taken_q, out_pred_taken_d;
    logic [31:0]            out_pred_target_q, out_pred_target_d;

    logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
    logic [TAGW-1:0]        btb_tag_q [BTB_ENTRIES];
    logic [29:0]            btb_tgt_q [BTB_ENTRIES];

    logic [IDX-1:0]         rd_idx, wr_idx;
    logic [TAGW-1:0]        rd_tag, wr_tag;
    logic [31:0]            btb_target;
    logic                   hit, pred_use, advance;
    logic                   unused_addr_bits;

    assign rd_idx     = pc_q[IDX+1:2];
    assign rd_tag     = pc_q[31:IDX+2];
    assign wr_idx     = btb_update_pc[IDX+1:2];
    assign wr_tag     = btb_update_pc[31:IDX+2];
    assign btb_target = {btb_tgt_q[rd_idx], 2'b00};

    assign hit      = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);
    assign pred_use = pred_taken && hit;
    assign advance  = !out_valid_q || out_ready;

    assign unused_addr_bits = ^{redirect_pc[1:0], btb_update_pc[1:0],
                                btb_update_target[1:0]};

    always_comb begin
        pc_d              = pc_q;
        out_valid_d       = out_valid_q;
        out_pc_d          = out_pc_q;
        out_pred_taken_d  = out_pred_taken_q;
        out_pred_target_d = out_pred_target_q;
        if (redirect) begin
            // The lookup in flight is dropped along with any held packet.
            pc_d        = {redirect_pc[31:2], 2'b00};
            out_valid_d = 1'b0;
        end else if (advance) begin
            out_valid_d       = 1'b1;
            out_pc_d          = {pc_q[31:2], 2'b00};
            out_pred_taken_d  = pred_use;
            out_pred_target_d = hit ? btb_target : 32'h0;
            pc_d              = pred_use ? btb_target : pc_q + 32'd4;
        end
    end

    always_comb begin
        btb_valid_d = btb_valid_q;
        if (btb_update) begin
            btb_valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q              <= {RESET_PC[31:2], 2'b00};
            out_valid_q       <= 1'b0;
            out_pc_q          <= 32'h0;
            out_pred_taken_q  <= 1'b0;
            out_pred_target_q <= 32'h0;
            btb_valid_q       <= '0;
        end else begin
            pc_q              <= pc_d;
            out_valid_q       <= out_valid_d;
            out_pc_q          <= out_pc_d;
            out_pred_taken_q  <= out_pred_taken_d;
            out_pred_target_q <= out_pred_target_d;
            btb_valid_q       <= btb_valid_d;
        end
    end

    // Tag and target payload is qualified by the valid bits, so no reset.
    always_ff @(posedge clk) begin
        if (btb_update && !rst) begin
            btb_tag_q[wr_idx] <= wr_tag;
            btb_tgt_q[wr_idx] <= btb_update_target[31:2];
        end
    end

    assign pred_addr       = pc_q;
    assign out_valid       = out_valid_q;
    assign out_pc          = out_pc_q;
    assign out_pred_taken  = out_pred_taken_q;
    assign out_pred_target = out_pred_target_q;

endmodule

// File: tb/tb_cpu_fetch_pc.sv
// Bench for cpu_fetch_pc: directed scenarios then random traffic,
// packets checked by a queue-based scoreboard against a transaction model.
module tb_cpu_fetch_pc;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam int          NENT   = 16;

    logic        clk;
    logic        rst;
    logic [31:0] pred_addr;
    logic        pred_taken;
    logic        btb_update;
    logic [31:0] btb_update_pc;
    logic [31:0] btb_update_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic        out_pred_taken;
    logic [31:0] out_pred_target;

    cpu_fetch_pc #(
        .RESET_PC   (RST_PC),
        .BTB_ENTRIES(NENT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_addr        (pred_addr),
        .pred_taken       (pred_taken),
        .btb_update       (btb_update),
        .btb_update_pc    (btb_update_pc),
        .btb_update_target(btb_update_target),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_pred_taken   (out_pred_taken),
        .out_pred_target  (out_pred_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
    } pkt_t;

    pkt_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Model: fetch address, what the output register shows, and a BTB
    // remembered as "which branch word address owns each slot, and where it goes".
    logic [31:0] m_pc;
    logic        m_ov;
    pkt_t        m_out;
    bit          m_bv   [NENT];
    logic [29:0] m_bpc  [NENT];
    logic [29:0] m_btgt [NENT];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int   i;
        bit   hit;
        bit   use_t;
        pkt_t p;
        if (rst) begin
            m_pc  = RST_PC;
            m_ov  = 1'b0;
            m_out = '{32'h0, 1'b0, 32'h0};
            foreach (m_bv[k]) m_bv[k] = 1'b0;
            sb.delete();
            return;
        end
        i     = int'((m_pc >> 2) % NENT);
        hit   = m_bv[i] && (m_bpc[i] == m_pc[31:2]);
        use_t = pred_taken && hit;
        if (redirect) begin
            if (m_ov && !out_ready) void'(sb.pop_back());
            m_ov = 1'b0;
            m_pc = redirect_pc & ~32'h3;
        end else if (!m_ov || out_ready) begin
            p.pc  = m_pc;
            p.tk  = use_t;
            p.tgt = hit ? {m_btgt[i], 2'b00} : 32'h0;
            sb.push_back(p);
            m_out = p;
            m_ov  = 1'b1;
            m_pc  = use_t ? {m_btgt[i], 2'b00} : m_pc + 32'd4;
        end
        if (btb_update) begin
            i         = int'((btb_update_pc >> 2) % NENT);
            m_bv[i]   = 1'b1;
            m_bpc[i]  = btb_update_pc[31:2];
            m_btgt[i] = btb_update_target[31:2];
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("pred_addr", pred_addr, m_pc);
        chk("out_valid", {31'h0, out_valid}, {31'h0, m_ov});
        if (m_ov) begin
            chk("held_pc", out_pc, m_out.pc);
            chk("held_tk", {31'h0, out_pred_taken}, {31'h0, m_out.tk});
            chk("held_tgt", out_pred_target, m_out.tgt);
        end
    endtask

    task automatic idle_inputs();
        pred_taken = 1'b0;
        btb_update = 1'b0;
        redirect   = 1'b0;
    endtask

    always @(negedge clk) begin
        pkt_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual=pc %h required=none", out_pc);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_tk", {31'h0, out_pred_taken}, {31'h0, e.tk});
                chk("sb_tgt", out_pred_target, e.tgt);
            end
        end
    end

    logic [31:0] r;

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        btb_update_pc = 32'h0;
        btb_update_target = 32'h0;
        redirect_pc = 32'h0;
        idle_inputs();
        m_pc = 32'h0;
        m_ov = 1'b0;
        m_out = '{32'h0, 1'b0, 32'h0};

        step();
        step();
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_pred_addr", pred_addr, 32'h1000);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_tk", {31'h0, out_pred_taken}, 32'h0);
        chk("rst_out_tgt", out_pred_target, 32'h0);

        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("seq0", out_pc, 32'h1000);
        step();
        chk("seq1", out_pc, 32'h1004);

        out_ready = 1'b0;
        btb_update = 1'b1;
        btb_update_pc = 32'h1008;
        btb_update_target = 32'h2000;
        step();
        btb_update = 1'b0;
        step();
        step();
        chk("stall_pc", out_pc, 32'h1004);
        chk("stall_addr", pred_addr, 32'h1008);
        chk("stall_valid", {31'h0, out_valid}, 32'h1);

        out_ready = 1'b1;
        pred_taken = 1'b1;
        step();
        chk("hit_pc", out_pc, 32'h1008);
        chk("hit_tk", {31'h0, out_pred_taken}, 32'h1);
        chk("hit_tgt", out_pred_target, 32'h2000);
        pred_taken = 1'b0;
        step();
        chk("hit_next", out_pc, 32'h2000);

        redirect = 1'b1;
        redirect_pc = 32'h1048;
        step();
        redirect = 1'b0;
        pred_taken = 1'b1;
        step();
        chk("alias_pc", out_pc, 32'h1048);
        chk("alias_tk", {31'h0, out_pred_taken}, 32'h0);
        pred_taken = 1'b0;
        step();
        chk("alias_next", out_pc, 32'h104C);

        out_ready = 1'b0;
        step();
        redirect = 1'b1;
        redirect_pc = 32'h3002;
        step();
        chk("redir_valid", {31'h0, out_valid}, 32'h0);
        chk("redir_addr", pred_addr, 32'h3000);
        redirect = 1'b0;
        step();
        chk("redir_pc", out_pc, 32'h3000);
        chk("redir_valid2", {31'h0, out_valid}, 32'h1);

        out_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        btb_update = 1'b1;
        btb_update_pc = 32'h1010;
        btb_update_target = 32'h4000;
        step();
        idle_inputs();
        step();
        chk("wrap_last", out_pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_zero", out_pc, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h1010;
        step();
        redirect = 1'b0;
        pred_taken = 1'b1;
        step();
        chk("simul_tk", {31'h0, out_pred_taken}, 32'h1);
        chk("simul_tgt", out_pred_target, 32'h4000);
        pred_taken = 1'b0;

        out_ready = 1'b0;
        step();
        rst = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h8000;
        btb_update = 1'b1;
        btb_update_pc = 32'h1000;
        btb_update_target = 32'h5000;
        step();
        chk("mrst_valid", {31'h0, out_valid}, 32'h0);
        chk("mrst_addr", pred_addr, 32'h1000);
        chk("mrst_pc", out_pc, 32'h0);
        rst = 1'b0;
        idle_inputs();
        out_ready = 1'b1;
        pred_taken = 1'b1;
        step();
        chk("mrst_blocked", {31'h0, out_pred_taken}, 32'h0);
        pred_taken = 1'b0;
        step();
        pred_taken = 1'b1;
        step();
        chk("mrst_cleared", {31'h0, out_pred_taken}, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            out_ready = rst ? 1'b0 : ($urandom_range(0, 9) < 7);
            pred_taken = $urandom_range(0, 1) == 1;
            btb_update = $urandom_range(0, 3) == 0;
            r = $urandom();
            btb_update_pc = 32'h1000 + {r[7:2], 2'b00} + {30'h0, r[9:8]};
            r = $urandom();
            btb_update_target = 32'h1000 + {r[7:2], 2'b00} + {30'h0, r[9:8]};
            redirect = $urandom_range(0, 9) == 0;
            r = $urandom();
            redirect_pc = ($urandom_range(0, 19) == 0) ? r :
                          32'h1000 + {r[7:2], 2'b00} + {30'h0, r[9:8]};
            step();
        end

        rst = 1'b0;
        idle_inputs();
        out_ready = 1'b1;
        repeat (4) step();
        chk("sb_level", sb.size(), {31'h0, m_ov});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_fetch_pc.md
CPU_FETCH_PC -- requirements
Module: cpu_fetch_pc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter BTB_ENTRIES, default 16, is the number of direct-mapped BTB entries; it SHALL be a power of two and at least 2.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: reset, synchronous and active-high.
- pred_addr, out, 32: lookup address to the branch predictor; equals the current PC combinationally.
- pred_taken, in, 1: predictor taken/not-taken answer for pred_addr, same cycle.
- btb_update, in, 1: BTB write strobe from execute.
- btb_update_pc, in, 32: address of the branch being written.
- btb_update_target, in, 32: resolved branch target.
- redirect, in, 1: execute flush/redirect request (mispredict).
- redirect_pc, in, 32: new fetch address.
- out_valid, out, 1: fetch packet valid.
- out_ready, in, 1: downstream accepts the packet.
- out_pc, out, 32: PC of the packet.
- out_pred_taken, out, 1: packet predicted taken.
- out_pred_target, out, 32: predicted target; meaningful only when out_pred_taken=1.

Function
REQ-004 BTB index SHALL be pc[IDX+1:2] and tag pc[31:IDX+2], where IDX=log2(BTB_ENTRIES); each entry holds a valid bit, tag and 30-bit target.
REQ-005 hit SHALL be asserted when the indexed entry is valid and its tag matches the current PC; the BTB is read combinationally.
REQ-006 pred_use SHALL equal pred_taken AND hit; if pred_taken=1 but hit=0, the fetch is treated as not taken.
REQ-007 advance SHALL be asserted when out_valid=0 OR out_ready=1.
REQ-008 On advance without redirect, the output register SHALL capture out_pc=pc, out_pred_taken=pred_use and out_pred_target={target,2'b00} (0 on a miss), with out_valid=1; latency is one cycle from PC to packet.
REQ-009 next_pc priority SHALL be: redirect -> {redirect_pc[31:2],2'b00}; else advance and pred_use -> BTB target; else advance -> pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000); else hold pc.
REQ-010 redirect SHALL set out_valid=0 on the next edge, whether or not out_ready=1 and whether or not out_valid was set, and SHALL discard the current lookup.
REQ-011 While out_valid=1 and out_ready=0 without redirect, out_pc, out_pred_taken, out_pred_target and pc SHALL be held stable.
REQ-012 btb_update SHALL write valid=1, tag and btb_update_target[31:2] at the index of btb_update_pc on the edge; bits [1:0] of both addresses are ignored.
REQ-013 A same-cycle lookup of the index being written SHALL return the old contents; the new contents are visible from the next cycle.
REQ-014 btb_update and redirect in the same cycle SHALL both take effect.
REQ-015 pc[1:0] and out_pc[1:0] SHALL always be 2'b00.

Reset
REQ-016 While rst=1 on an edge: pc=RESET_PC, out_valid=0, out_pc=0, out_pred_taken=0, out_pred_target=0, and all BTB valid bits cleared.
REQ-017 rst SHALL take priority over redirect, btb_update and advance, including when asserted mid-stall or mid-redirect.
REQ-018 BTB tag and target storage need not be reset.

Verification
All scenarios use BTB_ENTRIES=16 and RESET_PC=0x1000.
REQ-019 Reset and sequential fetch: hold rst for 2 cycles, then release with out_ready=1 and pred_taken=0 -> out_valid=0 during reset, pred_addr=0x1000; out_pc then runs 0x1000, 0x1004, 0x1008 on consecutive cycles.
REQ-020 Backpressure: hold out_ready=0 for 3 cycles while out_pc=0x1004 -> out_pc, pred_addr (0x1008) and out_valid are stable; on release the next out_pc is 0x1008.
REQ-021 Taken hit: write btb_update_pc=0x1008, btb_update_target=0x2000, then drive pred_taken=1 when pred_addr=0x1008 -> packet out_pc=0x1008, out_pred_taken=1, out_pred_target=0x2000; the next packet has out_pc=0x2000.
REQ-022 Alias miss: with the entry above written, drive pred_taken=1 at pred_addr=0x1048 (same index, different tag) -> out_pred_taken=0; the next packet has out_pc=0x104C.
REQ-023 Redirect under stall: with out_valid=1 and out_ready=0, pulse redirect with redirect_pc=0x3002 -> next cycle out_valid=0 and pred_addr=0x3000; the following cycle out_pc=0x3000 and out_valid=1.
REQ-024 Wrap and simultaneous events: pulse redirect to 0xFFFF_FFFC together with btb_update (pc 0x1010, target 0x4000) -> the packet after 0xFFFF_FFFC has out_pc=0x0000_0000; a later lookup of 0x1010 hits with target 0x4000.
